adc_acq_sequencer: RTL and testbench
====================================

ADC_ACQ_SEQUENCER -- requirements
Module: adc_acq_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, sample buffer depth (power of two).
REQ-002 SHALL have parameter MIN_PERIOD, default 70, minimum clk_in cycles between conversion triggers.
REQ-003 SHALL have parameter TIMEOUT, default 128, max clk_in cycles from trigger to adc_ready.
REQ-004 clk_in  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; sampled only in IDLE, begins an acquisition run.
REQ-007 abort  in  1  level; terminates the run.
REQ-008 n_samples  in  8  samples per run, latched at start.
REQ-009 period  in  16  trigger-to-trigger interval in clk_in cycles, latched at start.
REQ-010 adc_ctrl  out  1  one-cycle conversion request to the ADC controller (single mode).
REQ-011 adc_ready  in  1  one-cycle pulse, conversion complete.
REQ-012 adc_data  in  12  conversion result, valid when adc_ready=1.
REQ-013 rd_en  in  1  host FIFO pop.
REQ-014 rd_data  out  12  FIFO head, registered.
REQ-015 fifo_empty, fifo_full  out  1 each  FIFO status.
REQ-016 busy  out  1  run in progress.
REQ-017 done  out  1  one-cycle pulse at run end.
REQ-018 overrun, timeout_err  out  1 each  sticky error flags.

Function
REQ-019 States SHALL be IDLE, TRIG, WAIT_RDY, HOLD, DONE.
REQ-020 IDLE->TRIG when start=1 and n_samples!=0; IDLE->DONE when start=1 and n_samples=0; latch n_samples, period, clear overrun/timeout_err on that edge.
REQ-021 TRIG SHALL assert adc_ctrl for exactly one cycle, reload period timer and timeout counter, ->WAIT_RDY.
REQ-022 WAIT_RDY: on adc_ready push adc_data into FIFO, increment sample count, ->HOLD (or ->DONE if count reaches latched n_samples).
REQ-023 WAIT_RDY: if TIMEOUT cycles elapse since trigger without adc_ready, set timeout_err, ->DONE.
REQ-024 HOLD ->TRIG when period timer reaches effective period; effective period = max(latched period, MIN_PERIOD).
REQ-025 Period timer SHALL count from the TRIG cycle, so consecutive adc_ctrl pulses are exactly effective-period cycles apart when adc_ready arrives in time.
REQ-026 DONE SHALL pulse done for one cycle, ->IDLE; busy=1 in TRIG, WAIT_RDY, HOLD, 0 otherwise.
REQ-027 abort=1 in any non-IDLE state SHALL ->DONE next cycle; no further adc_ctrl; a coincident adc_ready sample is still pushed.
REQ-028 start while busy SHALL be ignored; adc_ready outside WAIT_RDY SHALL be ignored.
REQ-029 Push into full FIFO without simultaneous pop SHALL drop the sample and set overrun; push and pop same cycle when full SHALL succeed without overrun.
REQ-030 Pop on empty FIFO SHALL be ignored; rd_data updates the cycle after an accepted pop.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter log2(FIFO_DEPTH)+1 bits.
REQ-032 FIFO contents SHALL persist across runs; only rst clears it.

Reset
REQ-033 On rst: state IDLE, adc_ctrl=0, busy=0, done=0, overrun=0, timeout_err=0, rd_data=0, FIFO empty (fifo_empty=1, fifo_full=0), all counters 0.
REQ-034 rst mid-run SHALL take priority over every other input in the same cycle.

Structure
REQ-035 State encoding, MIN_PERIOD and TIMEOUT defaults SHALL live in shared package adc_acq_pkg.
REQ-036 FIFO SHALL be sub-module sample_fifo (12-bit, parameterised depth, synchronous reset).

Verification
REQ-037 n_samples=3, period=100, adc_ready 66 cycles after each adc_ctrl -> 3 adc_ctrl pulses 100 cycles apart, 3 FIFO entries, one done, busy low after.
REQ-038 period=10 -> adc_ctrl pulses 70 cycles apart.
REQ-039 adc_ready withheld -> timeout_err=1 and done 128 cycles after adc_ctrl, FIFO unchanged.
REQ-040 n_samples=20, no pops, FIFO_DEPTH=16 -> 16 entries, overrun=1, first 16 values read back in order.
REQ-041 abort during HOLD of sample 2 -> done next cycle, no further adc_ctrl, 2 entries in FIFO.
REQ-042 n_samples=0 -> done one cycle after start, no adc_ctrl; rst mid-run -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/adc_acq_pkg.sv
// Shared types and defaults for the ADC acquisition sequencer.
// The state encoding is exported so checkers can bind to the debug state output.
package adc_acq_pkg;

    localparam int SAMPLE_W       = 12;
    localparam int MIN_PERIOD_DEF = 70;
    localparam int TIMEOUT_DEF    = 128;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TRIG     = 3'd1,
        WAIT_RDY = 3'd2,
        HOLD     = 3'd3,
        DONE     = 3'd4
    } acq_state_t;

    // The ADC cannot be retriggered faster than floor_p cycles.
    function automatic logic [15:0] eff_period(input logic [15:0] p,
                                               input logic [15:0] floor_p);
        return (p > floor_p) ? p : floor_p;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with a registered read port: rd_data shows the popped
// word the cycle after an accepted pop. A full FIFO accepts a push paired with a pop.
module sample_fifo
    import adc_acq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = SAMPLE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pop_data <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_acq_sequencer.sv
// Acquisition run sequencer: triggers the ADC at a fixed period, collects
// n_samples results into sample_fifo, and flags overrun and conversion timeout.
module adc_acq_sequencer
    import adc_acq_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          n_samples,
    input  logic [15:0]         period,
    output logic                adc_ctrl,
    input  logic                adc_ready,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                rd_en,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                fifo_empty,
    output logic                fifo_full,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic                timeout_err,
    output acq_state_t          fsm_state
);

    localparam logic [15:0] MIN_P   = 16'(MIN_PERIOD);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    acq_state_t  state_q;
    acq_state_t  state_d;
    logic [7:0]  n_q;
    logic [7:0]  count_q;
    logic [15:0] period_q;
    logic [15:0] age_q;
    logic [15:0] eff_m1;
    logic        push;
    logic        timeout_hit;
    logic        run_start;

    // Handshake: adc_ctrl is a one-cycle request; the converter answers with a
    // one-cycle adc_ready carrying adc_data. Only a ready seen in WAIT_RDY counts.
    assign push        = (state_q == WAIT_RDY) && adc_ready;
    assign timeout_hit = (state_q == WAIT_RDY) && !adc_ready && (age_q >= TO_LAST);
    assign run_start   = (state_q == IDLE) && start;
    assign eff_m1      = eff_period(period_q, MIN_P) - 16'd1;

    assign adc_ctrl  = (state_q == TRIG);
    assign busy      = (state_q == TRIG) || (state_q == WAIT_RDY) || (state_q == HOLD);
    assign done      = (state_q == DONE);
    assign fsm_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = (n_samples == 8'd0) ? DONE : TRIG;
            TRIG:     state_d = WAIT_RDY;
            WAIT_RDY: begin
                if (adc_ready) begin
                    state_d = (count_q + 8'd1 == n_q) ? DONE : HOLD;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            HOLD:     if (age_q >= eff_m1) state_d = TRIG;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (abort && busy) begin
            state_d = DONE;
        end
    end

    // age_q counts cycles since the last trigger; it times both the period and the timeout.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            count_q     <= '0;
            period_q    <= '0;
            age_q       <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (run_start) begin
                n_q         <= n_samples;
                period_q    <= period;
                count_q     <= '0;
                age_q       <= '0;
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (state_q == TRIG) begin
                age_q <= 16'd1;
            end else if (busy) begin
                age_q <= age_q + 16'd1;
            end
            if (push) begin
                count_q <= count_q + 8'd1;
            end
            if (push && fifo_full && !rd_en) begin
                overrun <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SAMPLE_W)
    ) u_fifo (
        .clk       (clk_in),
        .rst       (rst),
        .push      (push),
        .push_data (adc_data),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Self-checking bench for adc_acq_sequencer: ADC responder model, FIFO
// scoreboard queue, trigger/done timing monitor and directed run scenarios.
module tb_adc_acq_sequencer;
    import adc_acq_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  n_samples = '0;
    logic [15:0] period = '0;
    logic        adc_ctrl;
    logic        adc_ready = 1'b0;
    logic [11:0] adc_data = '0;
    logic        rd_en;
    logic        drain_rd = 1'b0;
    logic        model_rd = 1'b0;
    logic [11:0] rd_data;
    logic        fifo_empty, fifo_full, busy, done, overrun, timeout_err;
    acq_state_t  fsm_state;

    assign rd_en = drain_rd | model_rd;

    int          cyc = 0;
    int          vec_cnt = 0;
    int          miscompares = 0;

    logic [11:0] exp_q[$];
    int          sb_count = 0;
    bit          exp_ovr = 1'b0;
    int          ctrl_times[$];

    int          ready_delay = 10;
    bit          pop_with_ready = 1'b0;
    bit          pend = 1'b0;
    int          ready_at = 0;
    logic [11:0] pop_exp = '0;

    adc_acq_sequencer #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_in      (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .n_samples   (n_samples),
        .period      (period),
        .adc_ctrl    (adc_ctrl),
        .adc_ready   (adc_ready),
        .adc_data    (adc_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .fsm_state   (fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Trigger monitor
    always @(negedge clk) begin
        if (adc_ctrl) ctrl_times.push_back(cyc);
    end

    // ADC responder; every accepted result is pushed to the scoreboard queue
    always @(negedge clk) begin
        if (model_rd) begin
            model_rd = 1'b0;
            chk("pop_push_full", 32'(rd_data), 32'(pop_exp));
        end
        if (adc_ready) adc_ready = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend && cyc == ready_at) begin
                pend = 1'b0;
                adc_data = 12'($urandom_range(1, 4095));
                adc_ready = 1'b1;
                if (pop_with_ready && sb_count > 0) begin
                    pop_exp = exp_q.pop_front();
                    sb_count--;
                    model_rd = 1'b1;
                end
                if (sb_count < DEPTH) begin
                    exp_q.push_back(adc_data);
                    sb_count++;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            if (adc_ctrl && ready_delay >= 0) begin
                pend = 1'b1;
                ready_at = cyc + ready_delay;
            end
        end
    end

    // Driver tasks
    task automatic start_run(input int n, input int p, output int s);
        ctrl_times.delete();
        exp_ovr = 1'b0;
        @(negedge clk);
        start = 1'b1;
        n_samples = 8'(n);
        period = 16'(p);
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_ctrl(input int n, input int budget);
        int i;
        for (i = 0; i < budget && ctrl_times.size() < n; i++) @(negedge clk);
        if (ctrl_times.size() < n) chk("ctrl_wait_timeout", 32'(ctrl_times.size()), 32'(n));
    endtask

    task automatic drain(input int n);
        chk("pre_drain_empty", 32'(fifo_empty), 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drain_rd = 1'b1;
            @(negedge clk);
            drain_rd = 1'b0;
            if (exp_q.size() > 0) begin
                chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                sb_count--;
            end else begin
                chk("sb_underflow", 32'(exp_q.size()), 1);
            end
        end
        chk("post_drain_empty", 32'(fifo_empty), 1);
    endtask

    initial begin
        int s, t;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_adc_ctrl", 32'(adc_ctrl), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_state", 32'(fsm_state), 32'(IDLE));

        // Three samples, period 100, ready 66 cycles after each trigger
        ready_delay = 66;
        start_run(3, 100, s);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_first_ctrl", 32'(adc_ctrl), 1);
        wait_done(600, t);
        chk("t1_ctrl_count", 32'(ctrl_times.size()), 3);
        if (ctrl_times.size() == 3) begin
            chk("t1_ctrl0_time", 32'(ctrl_times[0]), 32'(s + 1));
            chk("t1_gap01", 32'(ctrl_times[1] - ctrl_times[0]), 100);
            chk("t1_gap12", 32'(ctrl_times[2] - ctrl_times[1]), 100);
            chk("t1_done_time", 32'(t), 32'(ctrl_times[2] + 67));
        end
        @(negedge clk);
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_overrun", 32'(overrun), 0);
        drain(3);

        // Short period is clamped to the minimum
        ready_delay = 5;
        start_run(3, 10, s);
        wait_done(400, t);
        chk("t2_ctrl_count", 32'(ctrl_times.size()), 3);
        if (ctrl_times.size() == 3) begin
            chk("t2_gap01", 32'(ctrl_times[1] - ctrl_times[0]), 70);
            chk("t2_gap12", 32'(ctrl_times[2] - ctrl_times[1]), 70);
        end

        // Withheld ready: timeout, FIFO keeps the three entries from before
        ready_delay = -1;
        start_run(2, 100, s);
        wait_done(300, t);
        chk("t3_ctrl_count", 32'(ctrl_times.size()), 1);
        if (ctrl_times.size() == 1) chk("t3_done_time", 32'(t), 32'(ctrl_times[0] + 128));
        chk("t3_timeout_err", 32'(timeout_err), 1);
        @(negedge clk);
        chk("t3_timeout_sticky", 32'(timeout_err), 1);
        drain(3);

        // 20 samples into a 16-deep FIFO without pops
        ready_delay = 3;
        start_run(20, 10, s);
        wait_done(2000, t);
        chk("t4_ctrl_count", 32'(ctrl_times.size()), 20);
        chk("t4_full", 32'(fifo_full), 1);
        chk("t4_overrun", 32'(overrun), 32'(exp_ovr));
        drain(16);

        // Zero-sample run: done right away, no trigger, flags cleared
        start_run(0, 100, s);
        chk("t6_done", 32'(done), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_overrun_cleared", 32'(overrun), 0);
        chk("t6_timeout_cleared", 32'(timeout_err), 0);
        repeat (5) @(negedge clk);
        chk("t6_no_ctrl", 32'(ctrl_times.size()), 0);

        // Fill, then push and pop in the same cycle while full
        ready_delay = 3;
        start_run(16, 10, s);
        wait_done(1400, t);
        chk("t8_full", 32'(fifo_full), 1);
        pop_with_ready = 1'b1;
        start_run(1, 10, s);
        wait_done(200, t);
        pop_with_ready = 1'b0;
        @(negedge clk);
        chk("t8_no_overrun", 32'(overrun), 0);
        chk("t8_still_full", 32'(fifo_full), 1);
        drain(16);

        // Abort during the hold after sample 2
        ready_delay = 10;
        start_run(5, 100, s);
        wait_ctrl(2, 300);
        repeat (20) @(negedge clk);
        chk("t5_in_hold", 32'(fsm_state), 32'(HOLD));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_done", 32'(done), 1);
        repeat (150) @(negedge clk);
        chk("t5_ctrl_count", 32'(ctrl_times.size()), 2);
        chk("t5_busy", 32'(busy), 0);
        drain(2);

        // Reset mid-run overrides start and abort
        start_run(5, 100, s);
        wait_ctrl(2, 300);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        chk("t7_state", 32'(fsm_state), 32'(IDLE));
        chk("t7_busy", 32'(busy), 0);
        chk("t7_adc_ctrl", 32'(adc_ctrl), 0);
        chk("t7_done", 32'(done), 0);
        chk("t7_empty", 32'(fifo_empty), 1);
        chk("t7_full", 32'(fifo_full), 0);
        chk("t7_rd_data", 32'(rd_data), 0);
        chk("t7_overrun", 32'(overrun), 0);
        chk("t7_timeout", 32'(timeout_err), 0);
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        exp_q.delete();
        sb_count = 0;
        repeat (150) @(negedge clk);
        chk("t7_no_ctrl_after", 32'(ctrl_times.size()), 2);
        chk("t7_still_empty", 32'(fifo_empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
